matrix_stream_loader: RTL and testbench
=======================================

# matrix_stream_loader

Parametrised successor to the fixed-width matrix reader: accepts a strobe-delimited word stream containing a three-word dimension header (M, K, N) followed by matrix A (M×K) and matrix B (K×N) elements. It emits one indexed write per element, with separate write enables for the A and B buffers. It sits between the host word interface and the operand RAMs of the parallel multiplier. Compared with the earlier reader, it adds generic data width and maximum dimension, incremental row/column counters (no divide or modulo), header range checking with an error pulse, and an optional column-major B input order.

## Interface
- DATA_W, 32, width of din and data
- MAX_DIM, 16, largest legal value of M, K and N
- DIM_W (localparam), $clog2(MAX_DIM+1), width of the dimension registers
- IDX_W (localparam), $clog2(MAX_DIM) (min 1), width of row and col

Ports:
- clk  in  1  sole clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- start_read  in  1  word strobe; each 0→1 transition delivers one din word
- din  in  DATA_W  input word, sampled on strobe rising edge
- dim_m, dim_k, dim_n  out  DIM_W each  captured header values
- wr_a  out  1  one-cycle pulse: data is an A element at (row, col)
- wr_b  out  1  one-cycle pulse: data is a B element at (row, col)
- row, col  out  IDX_W each  element coordinates, valid while wr_a or wr_b is high
- data  out  DATA_W  element value
- busy  out  1  high in any state other than HDR_M
- read_done  out  1  one-cycle pulse after the last B element
- err  out  1  one-cycle pulse on header rejection

## Operation
- Edge detect: strb_q is a registered copy of start_read. A cycle has an edge when start_read=1 and strb_q=0. All word captures happen on edge cycles only.
- States:
  - HDR_M: on edge, capture M, then go to HDR_K.
  - HDR_K: on edge, capture K, then go to HDR_N.
  - HDR_N: on edge, capture N, clear the counters, then go to LOAD_A.
  - LOAD_A: on each edge, emit an A element. After the M·K-th element, clear the counters and go to LOAD_B.
  - LOAD_B: on each edge, emit a B element. After the K·N-th element, go to DONE.
  - DONE: read_done=1 for one cycle, then go to HDR_M.
- Header check: a header word is rejected if din==0 or din>MAX_DIM, comparing the full DATA_W value so any nonzero upper bit also rejects. On rejection: err pulses, the state returns to HDR_M, and previously captured dims are kept.
- A counters (row-major): col increments each element; when col==K-1, col wraps to 0 and row increments.
- B counters (row-major by default): when col==N-1, col wraps to 0 and row increments.
- The last element is detected by comparing counters against the dims (row==last && col==last). No multiplier is used.
- wr_a, wr_b, err and read_done are never high together.
- Edges that occur in DONE are dropped.
- Reset in any state: return to HDR_M immediately, all outputs clear, and the counters clear. A partially loaded matrix is abandoned.

## Timing
- Reset values:
  - state=HDR_M, strb_q=1 (a strobe held high through reset is ignored until it falls)
  - wr_a=wr_b=0, read_done=0, err=0, busy=0
  - row=col=0, data=0, dim_m=dim_k=dim_n=0
- Element latency: for an edge in cycle t, wr_a/wr_b, row, col and data are registered and valid in cycle t+1 only.
- data, row and col hold their values between writes.
- err is asserted in cycle t+1 after the rejecting edge.
- read_done is asserted two cycles after the last-B edge: DONE is entered at t+1, and the pulse is visible from the registered DONE decode.
- busy is combinational from state.
- Minimum strobe period is 2 cycles (high 1, low 1). Edges closer than that are impossible by construction.

## Configuration
- Macro: MATRIX_STREAM_LOADER_BCOLMAJOR_EN.
- Defined: B elements arrive column-major. row increments each element, and when row==K-1 it wraps to 0 and col increments. The last element is still at (K-1, N-1).
- Undefined: B elements arrive row-major, identical to A handling.
- The A path is unaffected either way.

## Test plan
- Reset, then header 2,3,2, then A words 1..6 and B words 7..12 → wr_a emits (0,0)=1, (0,1)=2, (0,2)=3, (1,0)=4, (1,1)=5, (1,2)=6. wr_b emits (0,0)=7 … (2,1)=12. read_done pulses once, 2 cycles after the word-12 edge. busy falls with it.
- Header word 0, then MAX_DIM+1, then 0x0001_0002 → err pulses 3 times, state stays HDR_M, no wr_a. A following valid header 1,1,1 with words 5, 9 → wr_a (0,0)=5, wr_b (0,0)=9.
- start_read held high across reset release → no capture until it goes low then high again.
- Assert reset during LOAD_A after 3 of 6 elements → outputs clear the next cycle. A fresh 1,1,1 load then completes correctly.
- MATRIX_STREAM_LOADER_BCOLMAJOR_EN defined, header 2,3,2, B words 7..12 → wr_b emits (0,0)=7, (1,0)=8, (2,0)=9, (0,1)=10, (1,1)=11, (2,1)=12.
- MAX_DIM=16, header 16,16,16 → exactly 256 wr_a and 256 wr_b pulses. Last coordinates are (15,15). No counter overflow.

Source files
------------

// File: rtl/matrix_stream_loader.sv
// Strobe-driven loader: (M, K, N) header, then A (MxK) and B (KxN) elements as indexed writes.
// Define MATRIX_STREAM_LOADER_BCOLMAJOR_EN to accept B elements in column-major order.
module matrix_stream_loader #(
    parameter int DATA_W  = 32,
    parameter int MAX_DIM = 16,
    localparam int DIM_W  = $clog2(MAX_DIM + 1),
    localparam int IDX_W  = (MAX_DIM > 1) ? $clog2(MAX_DIM) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_read,
    input  logic [DATA_W-1:0] din,
    output logic [DIM_W-1:0]  dim_m,
    output logic [DIM_W-1:0]  dim_k,
    output logic [DIM_W-1:0]  dim_n,
    output logic              wr_a,
    output logic              wr_b,
    output logic [IDX_W-1:0]  row,
    output logic [IDX_W-1:0]  col,
    output logic [DATA_W-1:0] data,
    output logic              busy,
    output logic              read_done,
    output logic              err
);

    typedef enum logic [2:0] {HDR_M, HDR_K, HDR_N, LOAD_A, LOAD_B, DONE} state_t;

    state_t           state, state_n;
    logic             strb_q;
    logic [IDX_W-1:0] cnt_r, cnt_c;
    logic             edge_s, hdr_bad;
    logic             r_m_end, r_k_end, c_k_end, c_n_end, last_a, last_b;

    always_comb begin
        edge_s  = start_read & ~strb_q;
        hdr_bad = (din == '0) || (din > DATA_W'(MAX_DIM));
        r_m_end = DIM_W'(cnt_r) == (dim_m - DIM_W'(1));
        r_k_end = DIM_W'(cnt_r) == (dim_k - DIM_W'(1));
        c_k_end = DIM_W'(cnt_c) == (dim_k - DIM_W'(1));
        c_n_end = DIM_W'(cnt_c) == (dim_n - DIM_W'(1));
        last_a  = r_m_end && c_k_end;
        last_b  = r_k_end && c_n_end;
        busy    = (state != HDR_M);
    end

    always_ff @(posedge clk) begin
        if (reset) state <= HDR_M;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            HDR_M:   if (edge_s) state_n = hdr_bad ? HDR_M : HDR_K;
            HDR_K:   if (edge_s) state_n = hdr_bad ? HDR_M : HDR_N;
            HDR_N:   if (edge_s) state_n = hdr_bad ? HDR_M : LOAD_A;
            LOAD_A:  if (edge_s && last_a) state_n = LOAD_B;
            LOAD_B:  if (edge_s && last_b) state_n = DONE;
            DONE:    state_n = HDR_M;
            default: state_n = HDR_M;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            // strb_q starts high so a strobe held through reset must fall before it counts
            strb_q    <= 1'b1;
            wr_a      <= 1'b0;
            wr_b      <= 1'b0;
            err       <= 1'b0;
            read_done <= 1'b0;
            row       <= '0;
            col       <= '0;
            data      <= '0;
            dim_m     <= '0;
            dim_k     <= '0;
            dim_n     <= '0;
            cnt_r     <= '0;
            cnt_c     <= '0;
        end else begin
            strb_q    <= start_read;
            wr_a      <= 1'b0;
            wr_b      <= 1'b0;
            err       <= 1'b0;
            read_done <= (state == DONE);
            if (edge_s) begin
                case (state)
                    HDR_M: begin
                        if (hdr_bad) err <= 1'b1;
                        else         dim_m <= din[DIM_W-1:0];
                    end
                    HDR_K: begin
                        if (hdr_bad) err <= 1'b1;
                        else         dim_k <= din[DIM_W-1:0];
                    end
                    HDR_N: begin
                        if (hdr_bad) err <= 1'b1;
                        else begin
                            dim_n <= din[DIM_W-1:0];
                            cnt_r <= '0;
                            cnt_c <= '0;
                        end
                    end
                    LOAD_A: begin
                        wr_a <= 1'b1;
                        row  <= cnt_r;
                        col  <= cnt_c;
                        data <= din;
                        if (last_a) begin
                            cnt_r <= '0;
                            cnt_c <= '0;
                        end else if (c_k_end) begin
                            cnt_c <= '0;
                            cnt_r <= cnt_r + IDX_W'(1);
                        end else begin
                            cnt_c <= cnt_c + IDX_W'(1);
                        end
                    end
                    LOAD_B: begin
                        wr_b <= 1'b1;
                        row  <= cnt_r;
                        col  <= cnt_c;
                        data <= din;
`ifdef MATRIX_STREAM_LOADER_BCOLMAJOR_EN
                        if (last_b) begin
                            cnt_r <= '0;
                            cnt_c <= '0;
                        end else if (r_k_end) begin
                            cnt_r <= '0;
                            cnt_c <= cnt_c + IDX_W'(1);
                        end else begin
                            cnt_r <= cnt_r + IDX_W'(1);
                        end
`else
                        if (last_b) begin
                            cnt_r <= '0;
                            cnt_c <= '0;
                        end else if (c_n_end) begin
                            cnt_c <= '0;
                            cnt_r <= cnt_r + IDX_W'(1);
                        end else begin
                            cnt_c <= cnt_c + IDX_W'(1);
                        end
`endif
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_matrix_stream_loader.sv
// Directed bench for matrix_stream_loader (DATA_W=32, MAX_DIM=16); follows MATRIX_STREAM_LOADER_BCOLMAJOR_EN.
module tb_matrix_stream_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_read;
    logic [31:0] din;
    logic [4:0]  dim_m, dim_k, dim_n;
    logic        wr_a, wr_b;
    logic [3:0]  row, col;
    logic [31:0] data;
    logic        busy, read_done, err;

    int checks = 0;
    int errors = 0;
    int overlap = 0;

    matrix_stream_loader #(.DATA_W(32), .MAX_DIM(16)) dut (
        .clk(clk), .reset(reset), .start_read(start_read), .din(din),
        .dim_m(dim_m), .dim_k(dim_k), .dim_n(dim_n),
        .wr_a(wr_a), .wr_b(wr_b), .row(row), .col(col), .data(data),
        .busy(busy), .read_done(read_done), .err(err)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if ($countones({wr_a, wr_b, err, read_done}) > 1) overlap++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Raise the strobe with a word; returns 1 time unit after the capturing edge.
    task automatic strobe(input logic [31:0] w);
        din = w;
        start_read = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic gap();
        start_read = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic hdr(input int m, input int k, input int n);
        strobe(32'(m)); gap();
        strobe(32'(k)); gap();
        strobe(32'(n)); gap();
    endtask

    task automatic elem(input int w, input bit is_b, input int r, input int c);
        strobe(32'(w));
        check("wr_a", 32'(wr_a), is_b ? 32'd0 : 32'd1);
        check("wr_b", 32'(wr_b), is_b ? 32'd1 : 32'd0);
        check("row", 32'(row), 32'(r));
        check("col", 32'(col), 32'(c));
        check("data", data, 32'(w));
        gap();
        check("pulse_end", 32'({wr_a, wr_b}), 32'd0);
        check("data_hold", data, 32'(w));
    endtask

    task automatic bad_hdr(input logic [31:0] w);
        strobe(w);
        check("err_pulse", 32'(err), 32'd1);
        check("err_busy", 32'(busy), 32'd0);
        check("err_no_wr", 32'(wr_a), 32'd0);
        gap();
        check("err_drop", 32'(err), 32'd0);
    endtask

    task automatic finish_done();
        check("done_early", 32'(read_done), 32'd0);
        check("busy_done", 32'(busy), 32'd1);
        gap();
        check("read_done", 32'(read_done), 32'd1);
        check("busy_fall", 32'(busy), 32'd0);
        gap();
        check("done_drop", 32'(read_done), 32'd0);
    endtask

    initial begin
        int cnt_a, cnt_b;
        reset = 1'b1;
        start_read = 1'b1;
        din = 32'd2;
        repeat (3) @(posedge clk);
        #1;
        check("rst_wr", 32'({wr_a, wr_b, err, read_done, busy}), 32'd0);
        check("rst_rc", 32'({row, col}), 32'd0);
        check("rst_data", data, 32'd0);
        check("rst_dims", 32'({dim_m, dim_k, dim_n}), 32'd0);

        // strobe held high through reset release must not capture
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("held_busy", 32'(busy), 32'd0);
        check("held_dim", 32'(dim_m), 32'd0);
        gap();

        hdr(2, 3, 2);
        check("dim_m", 32'(dim_m), 32'd2);
        check("dim_k", 32'(dim_k), 32'd3);
        check("dim_n", 32'(dim_n), 32'd2);
        check("busy_hdr", 32'(busy), 32'd1);
        for (int i = 0; i < 6; i++) elem(i + 1, 1'b0, i / 3, i % 3);
        for (int i = 0; i < 6; i++) begin
`ifdef MATRIX_STREAM_LOADER_BCOLMAJOR_EN
            strobe(32'(i + 7));
            check("b_row", 32'(row), 32'(i % 3));
            check("b_col", 32'(col), 32'(i / 3));
`else
            strobe(32'(i + 7));
            check("b_row", 32'(row), 32'(i / 2));
            check("b_col", 32'(col), 32'(i % 2));
`endif
            check("b_wr", 32'(wr_b), 32'd1);
            check("b_data", data, 32'(i + 7));
            if (i < 5) gap();
        end
        finish_done();

        bad_hdr(32'd0);
        bad_hdr(32'd17);
        bad_hdr(32'h0001_0002);
        check("dims_kept", 32'({dim_m, dim_k, dim_n}), 32'({5'd2, 5'd3, 5'd2}));
        hdr(1, 1, 1);
        elem(5, 1'b0, 0, 0);
        strobe(32'd9);
        check("b11_wr", 32'(wr_b), 32'd1);
        check("b11_rc", 32'({row, col}), 32'd0);
        check("b11_data", data, 32'd9);
        finish_done();

        // abandon a load midway through A
        hdr(2, 3, 2);
        for (int i = 0; i < 3; i++) elem(i + 1, 1'b0, i / 3, i % 3);
        reset = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_out", 32'({wr_a, wr_b, err, read_done, busy}), 32'd0);
        check("mid_rst_rc", 32'({row, col}), 32'd0);
        check("mid_rst_data", data, 32'd0);
        check("mid_rst_dims", 32'({dim_m, dim_k, dim_n}), 32'd0);
        reset = 1'b0;
        gap();
        hdr(1, 1, 1);
        elem(21, 1'b0, 0, 0);
        strobe(32'd22);
        check("post_rst_b", 32'(wr_b), 32'd1);
        check("post_rst_bd", data, 32'd22);
        finish_done();

        // full-size load
        cnt_a = 0;
        cnt_b = 0;
        hdr(16, 16, 16);
        for (int i = 0; i < 512; i++) begin
            strobe(32'(i));
            cnt_a += int'(wr_a);
            cnt_b += int'(wr_b);
            if (i == 255) check("last_a_rc", 32'({wr_a, row, col}), 32'({1'b1, 4'd15, 4'd15}));
            if (i < 511) gap();
        end
        check("last_b_rc", 32'({wr_b, row, col}), 32'({1'b1, 4'd15, 4'd15}));
        check("cnt_a", 32'(cnt_a), 32'd256);
        check("cnt_b", 32'(cnt_b), 32'd256);
        finish_done();

        check("exclusive", 32'(overlap), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
